scv_vram_responder: RTL and testbench

//  Bus-side responder for the uPD7800 CPU's external memory bus (A / DB_I / DB_O / RDB / WRB).
//  It owns one single-port VRAM array and serves two clients:
//   - the CPU bus, with decoded chip select, read-data return and a 1-deep posted-write buffer;
//   - the video fetch port, a request/acknowledge handshake.

---
 rtl/scv_vram_responder_if.sv | 29 ++
 rtl/scv_vram_responder.sv | 126 ++++++++++++
 tb/tb_scv_vram_responder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/scv_vram_responder_if.sv
// CPU external-bus and video-fetch signal bundle for the VRAM responder.
// The master side is the CPU bus plus the video fetcher; the slave side is the responder.
interface scv_vram_responder_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          NCS;
  logic [AW-1:0] A;
  logic          RDB;
  logic          WRB;
  logic [DW-1:0] DI;
  logic [DW-1:0] DO;
  logic          DO_OE;
  logic          VREQ;
  logic [AW-1:0] VA;
  logic          VACK;
  logic [DW-1:0] VDATA;
  logic          OVERRUN;

  modport master (
    output NCS, A, RDB, WRB, DI, VREQ, VA,
    input  DO, DO_OE, VACK, VDATA, OVERRUN
  );

  modport slave (
    input  NCS, A, RDB, WRB, DI, VREQ, VA,
    output DO, DO_OE, VACK, VDATA, OVERRUN
  );
endinterface

// File: rtl/scv_vram_responder.sv
// Single-port VRAM shared by the uPD7800 CPU bus and a video fetch port.
// One RAM slot per clock; losers become urgent next cycle, so both clients have bounded latency.
module scv_vram_responder #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic                 CLK,
  input  logic                 RES,
  scv_vram_responder_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RPEND, S_RDONE} rd_st_e;

  rd_st_e        st_q;
  logic          ncs_q, rdb_q, wrb_q;
  logic [AW-1:0] a_q;
  logic          wb_vld_q;
  logic [AW-1:0] wb_addr_q;
  logic [DW-1:0] wb_data_q;
  logic [AW-1:0] rd_addr_q;
  logic          r_urg_q, w_urg_q, vack_q, ovr_q;
  logic [DW-1:0] do_q, vdata_q;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic          rd_start, wr_start, fwd_hit;
  logic          r_req, w_req, v_req;
  logic          gnt_r, gnt_w, gnt_v;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;

  assign rd_start = ~bus.NCS & ~bus.RDB & (rdb_q | ncs_q | (bus.A != a_q));
  assign wr_start = ~bus.NCS & ~bus.WRB & (wrb_q | ncs_q);
  assign fwd_hit  = wb_vld_q & (wb_addr_q == bus.A);

  // A write being replaced this cycle gives up its slot: the old data is dropped.
  assign r_req = ~RES & (st_q == S_RPEND);
  assign w_req = ~RES & wb_vld_q & ~wr_start;
  assign v_req = ~RES & bus.VREQ & ~vack_q;

  always_comb begin
    gnt_r = 1'b0;
    gnt_w = 1'b0;
    gnt_v = 1'b0;
    if (r_req & r_urg_q)      gnt_r = 1'b1;
    else if (w_req & w_urg_q) gnt_w = 1'b1;
    else if (v_req)           gnt_v = 1'b1;
    else if (r_req)           gnt_r = 1'b1;
    else if (w_req)           gnt_w = 1'b1;
  end

  always_comb begin
    ram_addr = bus.VA;
    if (gnt_r)      ram_addr = rd_addr_q;
    else if (gnt_w) ram_addr = wb_addr_q;
  end

  assign ram_rdata = mem[ram_addr];

  // Array has no reset so contents survive RES.
  always_ff @(posedge CLK) begin
    if (gnt_w) mem[ram_addr] <= wb_data_q;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      st_q      <= S_IDLE;
      ncs_q     <= 1'b1;
      rdb_q     <= 1'b1;
      wrb_q     <= 1'b1;
      a_q       <= '0;
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      rd_addr_q <= '0;
      r_urg_q   <= 1'b0;
      w_urg_q   <= 1'b0;
      vack_q    <= 1'b0;
      ovr_q     <= 1'b0;
      do_q      <= '0;
      vdata_q   <= '0;
    end else begin
      ncs_q   <= bus.NCS;
      rdb_q   <= bus.RDB;
      wrb_q   <= bus.WRB;
      a_q     <= bus.A;
      r_urg_q <= r_req & ~gnt_r;
      w_urg_q <= wb_vld_q & ~gnt_w;
      vack_q  <= gnt_v;
      if (gnt_v) vdata_q <= ram_rdata;

      if (wr_start) begin
        wb_vld_q  <= 1'b1;
        wb_addr_q <= bus.A;
        wb_data_q <= bus.DI;
        if (wb_vld_q) ovr_q <= 1'b1;
      end else if (gnt_w) begin
        wb_vld_q <= 1'b0;
      end

      if (rd_start) begin
        if (fwd_hit) begin
          st_q <= S_RDONE;
          do_q <= wb_data_q;
        end else begin
          st_q      <= S_RPEND;
          rd_addr_q <= bus.A;
        end
      end else begin
        unique case (st_q)
          S_RPEND: if (gnt_r) begin
            st_q <= S_RDONE;
            do_q <= ram_rdata;
          end
          S_RDONE: if (bus.NCS | bus.RDB) st_q <= S_IDLE;
          default: st_q <= S_IDLE;
        endcase
      end
    end
  end

  // An address change while RDB stays low must not expose the stale byte.
  assign bus.DO_OE   = (st_q == S_RDONE) & ~bus.NCS & ~bus.RDB & ~rd_start;
  assign bus.DO      = do_q;
  assign bus.VACK    = vack_q;
  assign bus.VDATA   = vdata_q;
  assign bus.OVERRUN = ovr_q;
endmodule

// File: tb/tb_scv_vram_responder.sv
// Directed bench for scv_vram_responder: fill, CPU read/write, video sweep, forwarding, overrun, reset.
module tb_scv_vram_responder;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [DW-1:0] mdl [0:(1<<AW)-1];

  scv_vram_responder_if #(.AW(AW), .DW(DW)) bus ();
  scv_vram_responder #(.AW(AW), .DW(DW)) dut (.CLK(clk), .RES(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [AW-1:0] addr, input logic [DW-1:0] d, input int low_cyc);
    bus.A = addr; bus.DI = d; bus.NCS = 1'b0; bus.WRB = 1'b0;
    repeat (low_cyc) tick();
    bus.WRB = 1'b1; bus.NCS = 1'b1;
    mdl[addr] = d;
    repeat (3) tick();
  endtask

  task automatic wait_oe(input string tag, input int maxlat, input logic [DW-1:0] exp);
    int n;
    n = 0;
    while (bus.DO_OE !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n <= maxlat), 32'd1);
    chk({tag, "_do"}, bus.DO, exp);
  endtask

  task automatic cpu_read(input logic [AW-1:0] addr, input int maxlat, input string tag);
    bus.A = addr; bus.NCS = 1'b0; bus.RDB = 1'b0;
    #1;
    chk({tag, "_oe_start"}, bus.DO_OE, 1'b0);
    wait_oe(tag, maxlat, mdl[addr]);
    bus.RDB = 1'b1; bus.NCS = 1'b1;
    #1;
    chk({tag, "_oe_drop"}, bus.DO_OE, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.NCS = 1'b1; bus.RDB = 1'b1; bus.WRB = 1'b1; bus.A = '0; bus.DI = '0;
    bus.VREQ = 1'b0; bus.VA = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_do_oe", bus.DO_OE, 1'b0);
    chk("rst_vack", bus.VACK, 1'b0);
    chk("rst_do", bus.DO, 8'h00);
    chk("rst_vdata", bus.VDATA, 8'h00);
    chk("rst_ovr", bus.OVERRUN, 1'b0);

    // Known contents: byte(a) = a*7+3
    for (int a = 0; a < (1 << AW); a++) cpu_write(AW'(a), DW'(a * 7 + 3), 1);

    // Test 1: long write strobe, then uncontended read
    cpu_write(10'h123, 8'h5A, 4);
    cpu_read(10'h123, 2, "t1_rd");

    // Test 2: continuous video sweep against repeated CPU reads of 0x200
    fork
      begin
        for (int i = 0; i < (1 << AW); i++) begin
          int n;
          n = 0;
          bus.VA = AW'(i); bus.VREQ = 1'b1;
          do begin
            tick();
            n++;
          end while (bus.VACK !== 1'b1 && n < 6);
          // one masked VACK cycle plus at most two request cycles
          chk("t2_vlat", 32'(n <= 3), 32'd1);
          chk("t2_vdata", bus.VDATA, mdl[i]);
        end
        bus.VREQ = 1'b0;
      end
      begin
        repeat (60) cpu_read(10'h200, 3, "t2_rd");
      end
    join
    repeat (4) tick();

    // Test 3: read-after-write hits the write buffer while video holds the slot
    bus.A = 10'h010; bus.DI = 8'hA5; bus.NCS = 1'b0; bus.WRB = 1'b0;
    mdl[10'h010] = 8'hA5;
    tick();
    bus.WRB = 1'b1; bus.VREQ = 1'b1; bus.VA = 10'h300;
    tick();
    bus.RDB = 1'b0;
    #1;
    chk("t3_vack", bus.VACK, 1'b1);
    chk("t3_vdata", bus.VDATA, mdl[10'h300]);
    chk("t3_oe_start", bus.DO_OE, 1'b0);
    tick();
    chk("t3_fwd_oe", bus.DO_OE, 1'b1);
    chk("t3_fwd_do", bus.DO, 8'hA5);
    bus.RDB = 1'b1; bus.NCS = 1'b1;
    repeat (3) tick();
    cpu_read(10'h010, 3, "t3_rd_ram");
    bus.VREQ = 1'b0;
    repeat (4) tick();

    // Test 4: second write lands before the first could drain
    bus.A = 10'h001; bus.DI = 8'h11; bus.NCS = 1'b0; bus.WRB = 1'b0;
    tick();
    bus.WRB = 1'b1; bus.VREQ = 1'b1; bus.VA = 10'h3FF;
    tick();
    chk("t4_vack", bus.VACK, 1'b1);
    bus.A = 10'h002; bus.DI = 8'h22; bus.WRB = 1'b0; bus.VREQ = 1'b0;
    mdl[10'h002] = 8'h22;
    tick();
    bus.WRB = 1'b1; bus.NCS = 1'b1;
    #1;
    chk("t4_overrun", bus.OVERRUN, 1'b1);
    repeat (3) tick();
    cpu_read(10'h001, 2, "t4_rd1");
    cpu_read(10'h002, 2, "t4_rd2");
    chk("t4_overrun_sticky", bus.OVERRUN, 1'b1);

    // Test 5: reset while a read is pending and video is requesting
    bus.A = 10'h123; bus.NCS = 1'b0; bus.RDB = 1'b0; bus.VREQ = 1'b1; bus.VA = 10'h005;
    tick();
    rst = 1'b1;
    tick();
    chk("t5_do_oe", bus.DO_OE, 1'b0);
    chk("t5_vack", bus.VACK, 1'b0);
    chk("t5_do", bus.DO, 8'h00);
    chk("t5_vdata", bus.VDATA, 8'h00);
    chk("t5_ovr", bus.OVERRUN, 1'b0);
    rst = 1'b0; bus.RDB = 1'b1; bus.NCS = 1'b1; bus.VREQ = 1'b0;
    repeat (3) tick();
    cpu_read(10'h123, 2, "t5_rd");

    // Test 6: address change with RDB held low
    bus.A = 10'h050; bus.NCS = 1'b0; bus.RDB = 1'b0;
    tick();
    wait_oe("t6_a", 2, mdl[10'h050]);
    bus.A = 10'h051;
    #1;
    chk("t6_oe_drop", bus.DO_OE, 1'b0);
    wait_oe("t6_b", 3, mdl[10'h051]);
    bus.RDB = 1'b1; bus.NCS = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
